// File: rtl/dmem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : dmem_access_unit
// Description : MEM-stage sequencer that issues one word-aligned data-cache
//               request per load/store, stalls until the response arrives and
//               returns sign/zero-extended load data. Optional misalignment
//               trap enabled by defining DMEM_MISALIGN_TRAP_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_access_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_i,
  input  logic        mem_read_i,
  input  logic        mem_write_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] alu_out_i,
  input  logic [31:0] rs2_out_i,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_resp,
  output logic        dmem_read,
  output logic        dmem_write,
  output logic [31:0] dmem_address,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_mbe,
  output logic [31:0] load_data_o,
  output logic        load_valid_o,
  output logic        stall_o,
  output logic        misaligned_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [1:0] C_SZ_B = 2'b00;
  localparam logic [1:0] C_SZ_H = 2'b01;

  state_t      r_state;
  logic [1:0]  r_off;
  logic [2:0]  r_funct3;
  logic        r_is_load;

  logic        w_mem_op;
  logic        w_misaligned;
  logic        w_go;
  logic [1:0]  w_off;
  logic [3:0]  w_mbe;
  logic [31:0] w_wdata;

  assign w_mem_op = valid_i & (mem_read_i | mem_write_i);
  assign w_go     = w_mem_op & ~w_misaligned;
  assign stall_o  = ~rst & (((r_state == S_IDLE) & w_go) | (r_state == S_BUSY));

  // Offsets are force-aligned to the access size; with the trap enabled the
  // dropped bits never matter because misaligned accesses are not issued.
  always_comb begin
    w_off   = 2'b00;
    w_mbe   = 4'b1111;
    w_wdata = rs2_out_i;
    case (funct3_i[1:0])
      C_SZ_B: begin
        w_off   = alu_out_i[1:0];
        w_mbe   = 4'b0001 << alu_out_i[1:0];
        w_wdata = {4{rs2_out_i[7:0]}};
      end
      C_SZ_H: begin
        w_off   = {alu_out_i[1], 1'b0};
        w_mbe   = 4'b0011 << {alu_out_i[1], 1'b0};
        w_wdata = {2{rs2_out_i[15:0]}};
      end
      default: ;
    endcase
  end

`ifdef DMEM_MISALIGN_TRAP_EN
  always_comb begin
    w_misaligned = 1'b0;
    case (funct3_i[1:0])
      C_SZ_B:  w_misaligned = 1'b0;
      C_SZ_H:  w_misaligned = alu_out_i[0];
      default: w_misaligned = |alu_out_i[1:0];
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) misaligned_o <= 1'b0;
    else     misaligned_o <= (r_state == S_IDLE) & w_mem_op & w_misaligned;
  end
`else
  assign w_misaligned = 1'b0;
  assign misaligned_o = 1'b0;
`endif

  function automatic logic [31:0] extend_load(input logic [31:0] rdata,
                                              input logic [1:0]  off,
                                              input logic [2:0]  f3);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(rdata >> {off, 3'b000});
    h = off[1] ? rdata[31:16] : rdata[15:0];
    case (f3[1:0])
      C_SZ_B:  extend_load = f3[2] ? {24'b0, b} : {{24{b[7]}}, b};
      C_SZ_H:  extend_load = f3[2] ? {16'b0, h} : {{16{h[15]}}, h};
      default: extend_load = rdata;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_off        <= 2'b00;
      r_funct3     <= 3'b000;
      r_is_load    <= 1'b0;
      dmem_read    <= 1'b0;
      dmem_write   <= 1'b0;
      dmem_address <= 32'b0;
      dmem_wdata   <= 32'b0;
      dmem_mbe     <= 4'b0;
      load_data_o  <= 32'b0;
      load_valid_o <= 1'b0;
    end else begin
      load_valid_o <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_go) begin
            dmem_read    <= mem_read_i;
            dmem_write   <= ~mem_read_i;
            dmem_address <= {alu_out_i[31:2], 2'b00};
            dmem_wdata   <= w_wdata;
            dmem_mbe     <= w_mbe;
            r_off        <= w_off;
            r_funct3     <= funct3_i;
            r_is_load    <= mem_read_i;
            r_state      <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (dmem_resp) begin
            dmem_read    <= 1'b0;
            dmem_write   <= 1'b0;
            load_valid_o <= r_is_load;
            if (r_is_load) load_data_o <= extend_load(dmem_rdata, r_off, r_funct3);
            r_state      <= S_DONE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dmem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_access_unit
// Description : Scoreboard bench for dmem_access_unit (requests and loads).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i, mem_read_i, mem_write_i;
  logic [2:0]  funct3_i;
  logic [31:0] alu_out_i, rs2_out_i, dmem_rdata;
  logic        dmem_resp;
  logic        dmem_read, dmem_write;
  logic [31:0] dmem_address, dmem_wdata, load_data_o;
  logic [3:0]  dmem_mbe;
  logic        load_valid_o, stall_o, misaligned_o;

  always #5 clk = ~clk;

  dmem_access_unit dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .mem_read_i(mem_read_i),
    .mem_write_i(mem_write_i), .funct3_i(funct3_i), .alu_out_i(alu_out_i),
    .rs2_out_i(rs2_out_i), .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp),
    .dmem_read(dmem_read), .dmem_write(dmem_write), .dmem_address(dmem_address),
    .dmem_wdata(dmem_wdata), .dmem_mbe(dmem_mbe), .load_data_o(load_data_o),
    .load_valid_o(load_valid_o), .stall_o(stall_o), .misaligned_o(misaligned_o)
  );

  typedef struct packed {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  mbe;
  } req_t;

  req_t        req_q[$];
  logic [31:0] load_q[$];
  int          total = 0;
  int          bad   = 0;
  logic        prev_req = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Scoreboard: new requests and load completions are matched in order.
  always @(negedge clk) begin
    if (!rst && (dmem_read || dmem_write) && !prev_req) begin
      if (req_q.size() == 0) check("req_unexpected", 32'(req_q.size()), 1);
      else begin
        check("req_rd",   dmem_read,    req_q[0].rd);
        check("req_wr",   dmem_write,   req_q[0].wr);
        check("req_addr", dmem_address, req_q[0].addr);
        check("req_mbe",  dmem_mbe,     req_q[0].mbe);
        if (req_q[0].wr) check("req_wdata", dmem_wdata, req_q[0].wdata);
        req_q.delete(0);
      end
    end
    prev_req <= dmem_read | dmem_write;
    if (!rst && load_valid_o) begin
      if (load_q.size() == 0) check("load_unexpected", 32'(load_q.size()), 1);
      else begin
        check("load_data", load_data_o, load_q[0]);
        load_q.delete(0);
      end
    end
  end

  task automatic run_op(input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] rs2,
                        input logic [31:0] rdata, input int lat,
                        input logic [31:0] exp_addr, input logic [3:0] exp_mbe,
                        input logic [31:0] exp_wdata, input logic [31:0] exp_load);
    req_t r;
    int   stall_cnt, req_cnt, c;
    logic done;
    r.rd = rd; r.wr = wr & ~rd; r.addr = exp_addr; r.wdata = exp_wdata; r.mbe = exp_mbe;
    @(posedge clk); #1;
    valid_i = 1'b1; mem_read_i = rd; mem_write_i = wr; funct3_i = f3;
    alu_out_i = addr; rs2_out_i = rs2; dmem_rdata = rdata; dmem_resp = 1'b0;
    req_q.push_back(r);
    if (rd) load_q.push_back(exp_load);
    stall_cnt = 0; req_cnt = 0; c = 0; done = 1'b0;
    while (!done && c < 40) begin
      @(negedge clk);
      c++;
      if (dmem_read || dmem_write) req_cnt++;
      if (!stall_o) done = 1'b1;
      else begin
        stall_cnt++;
        @(posedge clk); #1;
        dmem_resp = (req_cnt + 1 == lat);
      end
    end
    check("op_done", done, 1'b1);
    check("stall_cycles", stall_cnt, lat + 1);
    check("req_cycles", req_cnt, lat);
    check("done_load_valid", load_valid_o, rd);
    check("done_misaligned", misaligned_o, 1'b0);
    @(posedge clk); #1;
    valid_i = 1'b0; mem_read_i = 1'b0; mem_write_i = 1'b0; dmem_resp = 1'b0;
    @(negedge clk);
    check("bubble_load_valid", load_valid_o, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; valid_i = 1'b1; mem_read_i = 1'b1; mem_write_i = 1'b0;
    funct3_i = 3'b010; alu_out_i = 32'h0; rs2_out_i = 32'h0;
    dmem_rdata = 32'h0; dmem_resp = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_stall", stall_o, 1'b0);
    check("rst_read", dmem_read, 1'b0);
    check("rst_write", dmem_write, 1'b0);
    check("rst_addr", dmem_address, 32'h0);
    check("rst_wdata", dmem_wdata, 32'h0);
    check("rst_mbe", dmem_mbe, 4'h0);
    check("rst_load_data", load_data_o, 32'h0);
    check("rst_load_valid", load_valid_o, 1'b0);
    check("rst_misaligned", misaligned_o, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0; valid_i = 1'b0; mem_read_i = 1'b0;

    // Spurious response while idle
    @(posedge clk); #1; dmem_resp = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    check("spur_stall", stall_o, 1'b0);
    @(posedge clk); #1; dmem_resp = 1'b0;
    @(negedge clk);
    check("spur_read", dmem_read, 1'b0);
    check("spur_write", dmem_write, 1'b0);
    check("spur_load_valid", load_valid_o, 1'b0);
    check("spur_load_data", load_data_o, 32'h0);
    check("spur_stall2", stall_o, 1'b0);

    //     rd wr f3      addr          rs2           rdata         lat exp_addr      mbe      wdata         load
    run_op(0, 1, 3'b010, 32'h1000_0004, 32'hDEAD_BEEF, 32'h0,        3, 32'h1000_0004, 4'b1111, 32'hDEAD_BEEF, 32'h0);
    run_op(1, 0, 3'b000, 32'h1000_0003, 32'h0,        32'h80FF_0000, 1, 32'h1000_0000, 4'b1000, 32'h0,        32'hFFFF_FF80);
    run_op(1, 0, 3'b100, 32'h1000_0003, 32'h0,        32'h80FF_0000, 1, 32'h1000_0000, 4'b1000, 32'h0,        32'h0000_0080);
    run_op(0, 1, 3'b001, 32'h1000_0002, 32'h1234_ABCD, 32'h0,        2, 32'h1000_0000, 4'b1100, 32'hABCD_ABCD, 32'h0);
    run_op(1, 0, 3'b101, 32'h1000_0002, 32'h0,        32'hABCD_0000, 1, 32'h1000_0000, 4'b1100, 32'h0,        32'h0000_ABCD);
    run_op(1, 0, 3'b001, 32'h1000_0002, 32'h0,        32'hABCD_0000, 4, 32'h1000_0000, 4'b1100, 32'h0,        32'hFFFF_ABCD);
    run_op(1, 0, 3'b010, 32'h2000_0008, 32'h0,        32'h1234_5678, 2, 32'h2000_0008, 4'b1111, 32'h0,        32'h1234_5678);
    run_op(1, 0, 3'b000, 32'h2000_0001, 32'h0,        32'h0000_7F00, 1, 32'h2000_0000, 4'b0010, 32'h0,        32'h0000_007F);
    run_op(0, 1, 3'b000, 32'h2000_0001, 32'h1122_3344, 32'h0,        1, 32'h2000_0000, 4'b0010, 32'h4444_4444, 32'h0);
    run_op(0, 1, 3'b011, 32'h2000_0010, 32'hA5A5_1234, 32'h0,        1, 32'h2000_0010, 4'b1111, 32'hA5A5_1234, 32'h0);
    check("load_data_hold", load_data_o, 32'h0000_007F);
    run_op(1, 1, 3'b010, 32'h2000_000C, 32'h55,       32'h0BAD_CAFE, 1, 32'h2000_000C, 4'b1111, 32'h0,        32'h0BAD_CAFE);

`ifdef DMEM_MISALIGN_TRAP_EN
    @(posedge clk); #1;
    valid_i = 1'b1; mem_read_i = 1'b1; funct3_i = 3'b010; alu_out_i = 32'h3000_0001;
    @(negedge clk);
    check("mis_stall", stall_o, 1'b0);
    check("mis_noreq", dmem_read, 1'b0);
    @(posedge clk); #1; valid_i = 1'b0; mem_read_i = 1'b0;
    @(negedge clk);
    check("mis_pulse", misaligned_o, 1'b1);
    check("mis_noreq2", dmem_read, 1'b0);
    check("mis_load_valid", load_valid_o, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    check("mis_pulse_end", misaligned_o, 1'b0);
`else
    run_op(1, 0, 3'b010, 32'h3000_0001, 32'h0, 32'hCAFE_F00D, 2, 32'h3000_0000, 4'b1111, 32'h0, 32'hCAFE_F00D);
    run_op(1, 0, 3'b101, 32'h3000_0003, 32'h0, 32'hBEEF_1111, 1, 32'h3000_0000, 4'b1100, 32'h0, 32'h0000_BEEF);
`endif

    // Reset during the second busy cycle; late response must be ignored
    begin
      req_t r;
      r.rd = 1'b1; r.wr = 1'b0; r.addr = 32'h4000_0010; r.wdata = 32'h0; r.mbe = 4'b1111;
      @(posedge clk); #1;
      valid_i = 1'b1; mem_read_i = 1'b1; mem_write_i = 1'b0; funct3_i = 3'b010;
      alu_out_i = 32'h4000_0010; dmem_rdata = 32'h7777_7777; dmem_resp = 1'b0;
      req_q.push_back(r);
      @(negedge clk);
      check("rb_idle_stall", stall_o, 1'b1);
      @(posedge clk); #1;
      @(negedge clk);
      check("rb_req", dmem_read, 1'b1);
      @(posedge clk); #1; rst = 1'b1;
      @(negedge clk);
      check("rb_stall_in_rst", stall_o, 1'b0);
      @(posedge clk); #1;
      rst = 1'b0; valid_i = 1'b0; mem_read_i = 1'b0; dmem_resp = 1'b1;
      @(negedge clk);
      check("rb_read_dropped", dmem_read, 1'b0);
      check("rb_stall", stall_o, 1'b0);
      check("rb_load_valid", load_valid_o, 1'b0);
      @(posedge clk); #1; dmem_resp = 1'b0;
      @(negedge clk);
      check("rb_load_valid2", load_valid_o, 1'b0);
      check("rb_read2", dmem_read, 1'b0);
      check("rb_load_data", load_data_o, 32'h0);
    end

    repeat (2) @(posedge clk);
    check("req_queue_empty", 32'(req_q.size()), 0);
    check("load_queue_empty", 32'(load_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
